// File: rtl/wdg_pkg.sv
// Shared constants and types for the windowed watchdog: key values, register offsets, SR layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wdg_pkg;

  localparam logic [15:0] KEY_START   = 16'hCCCC;
  localparam logic [15:0] KEY_REFRESH = 16'hAAAA;
  localparam logic [15:0] KEY_UNLOCK  = 16'h5555;

  // Byte offsets from the register base
  localparam logic [31:0] OFF_KR   = 32'h0000_0000;
  localparam logic [31:0] OFF_PR   = 32'h0000_0004;
  localparam logic [31:0] OFF_RLR  = 32'h0000_0008;
  localparam logic [31:0] OFF_SR   = 32'h0000_000C;
  localparam logic [31:0] OFF_WINR = 32'h0000_0010;
  localparam logic [31:0] OFF_EWR  = 32'h0000_0014;

  // SR bit positions
  localparam int SR_RUN      = 0;
  localparam int SR_EWIF     = 1;
  localparam int SR_UNLOCKED = 2;

  // EWR interrupt-enable bit
  localparam int EWR_EWIE = 15;

  // Largest effective prescaler select (divide by 256) and the counter width it needs
  localparam int unsigned PR_MAX  = 6;
  localparam int          PRESC_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } wdg_state_t;

  // Terminal count of the prescaler for a select value; selects above PR_MAX saturate
  function automatic logic [PRESC_W-1:0] presc_limit(input int unsigned sel);
    int unsigned eff;
    eff = (sel > PR_MAX) ? PR_MAX : sel;
    return 8'hFF >> (PR_MAX - eff);
  endfunction

endpackage

// File: rtl/wdg_prescaler.sv
// Clock divider for the watchdog counter: emits one tick every 2^(sel+2) enabled cycles.
// Latency: tick is combinational from the count register; clear takes effect next cycle.
// Backpressure: none; free-running while enabled, count held while disabled.
module wdg_prescaler
  import wdg_pkg::*;
#(
  parameter int PR_W = 3
) (
  input  logic            clk_m2s,
  input  logic            rst_m2s,
  input  logic            enable,
  input  logic            clear,
  input  logic [PR_W-1:0] sel,
  output logic            tick
);

  logic [PRESC_W-1:0] count_q;
  logic [PRESC_W-1:0] limit;

  assign limit = presc_limit(32'(sel));
  assign tick  = enable && (count_q == limit);

  // Count 0..limit while enabled; clear restarts the divide period
  always_ff @(posedge clk_m2s) begin
    if (rst_m2s) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= tick ? '0 : count_q + 1'b1;
    end
  end

endmodule

// File: rtl/wdg_window_wb.sv
// Windowed independent watchdog with early-warning interrupt behind a Wishbone classic slave.
// Latency: ack one cycle after strobe; register writes visible the cycle after ack; rst_wdg rises the cycle after the event.
// Backpressure: none; every strobe is acked after one cycle, no back-to-back acks.
module wdg_window_wb
  import wdg_pkg::*;
#(
  parameter int          DW         = 16,
  parameter int          CNT_W      = 12,
  parameter int          PR_W       = 3,
  parameter int          RST_CYCLES = 4,
  parameter logic [31:0] BASE_ADR   = 32'h0100_0000
) (
  input  logic          clk_m2s,
  input  logic          rst_m2s,
  input  logic [31:0]   adr_m2s,
  input  logic [DW-1:0] dat_m2s,
  input  logic          cyc_m2s,
  input  logic          stb_m2s,
  input  logic          we_m2s,
  output logic [DW-1:0] dat_s2m,
  output logic          ack_s2m,
  output logic          rst_wdg,
  output logic          irq_ew
);

  localparam int RST_W = $clog2(RST_CYCLES + 1);

  // Bus side
  logic          ack_q;
  logic [31:0]   off;
  logic          bus_wr;
  logic [15:0]   key;
  logic          kr_wr, pr_wr, rlr_wr, sr_wr, winr_wr, ewr_wr;
  logic          key_start, key_refresh;
  logic [DW-1:0] rd_dat;

  // Configuration and status
  logic             unlocked_q;
  logic [PR_W-1:0]  pr_q;
  logic [CNT_W-1:0] rlr_q;
  logic [CNT_W-1:0] winr_q;
  logic [CNT_W-1:0] ewthr_q;
  logic             ewie_q;
  logic             ewif_q;

  // Watchdog core
  wdg_state_t       state_q, state_d;
  logic             running;
  logic             start_go;
  logic             refresh_go;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_tick_next;
  logic             tick;
  logic             tick_eff;
  logic             timeout;
  logic             violation;
  logic             ew_set;
  logic             presc_clear;
  logic [RST_W-1:0] rst_left_q;

  // ---------------------------------------------------------------- bus decode
  assign off    = adr_m2s - BASE_ADR;
  assign bus_wr = ack_q && cyc_m2s && stb_m2s && we_m2s;
  assign key    = dat_m2s[15:0];

  assign kr_wr   = bus_wr && (off == OFF_KR);
  assign pr_wr   = bus_wr && (off == OFF_PR)   && unlocked_q;
  assign rlr_wr  = bus_wr && (off == OFF_RLR)  && unlocked_q;
  assign winr_wr = bus_wr && (off == OFF_WINR) && unlocked_q;
  assign ewr_wr  = bus_wr && (off == OFF_EWR)  && unlocked_q;
  assign sr_wr   = bus_wr && (off == OFF_SR);

  assign key_start   = kr_wr && (key == KEY_START);
  assign key_refresh = kr_wr && (key == KEY_REFRESH);

  // Single-cycle ack, one cycle after the strobe, never on consecutive cycles
  always_ff @(posedge clk_m2s) begin
    if (rst_m2s) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= cyc_m2s && stb_m2s && !ack_q;
    end
  end

  // Read mux; the data bus idles at zero outside a read ack
  always_comb begin
    rd_dat = '0;
    if (ack_q && !we_m2s) begin
      case (off)
        OFF_PR:   rd_dat[PR_W-1:0]  = pr_q;
        OFF_RLR:  rd_dat[CNT_W-1:0] = rlr_q;
        OFF_WINR: rd_dat[CNT_W-1:0] = winr_q;
        OFF_EWR: begin
          rd_dat[CNT_W-1:0] = ewthr_q;
          rd_dat[EWR_EWIE]  = ewie_q;
        end
        OFF_SR: begin
          rd_dat[SR_RUN]      = running;
          rd_dat[SR_EWIF]     = ewif_q;
          rd_dat[SR_UNLOCKED] = unlocked_q;
        end
        default: rd_dat = '0;
      endcase
    end
  end

  assign dat_s2m = rd_dat;
  assign ack_s2m = ack_q;

  // ---------------------------------------------------------------- registers
  // Key register drives the lock: only the unlock key opens, anything else closes
  always_ff @(posedge clk_m2s) begin
    if (rst_m2s) begin
      unlocked_q <= 1'b0;
    end else if (kr_wr) begin
      unlocked_q <= (key == KEY_UNLOCK);
    end
  end

  // Protected configuration registers, writable only while unlocked
  always_ff @(posedge clk_m2s) begin
    if (rst_m2s) begin
      pr_q    <= '0;
      rlr_q   <= '1;
      winr_q  <= '1;
      ewthr_q <= '0;
      ewie_q  <= 1'b0;
    end else begin
      if (pr_wr)   pr_q   <= dat_m2s[PR_W-1:0];
      if (rlr_wr)  rlr_q  <= dat_m2s[CNT_W-1:0];
      if (winr_wr) winr_q <= dat_m2s[CNT_W-1:0];
      if (ewr_wr) begin
        ewthr_q <= dat_m2s[CNT_W-1:0];
        ewie_q  <= dat_m2s[EWR_EWIE];
      end
    end
  end

  // Early-warning flag: sticky, write-1-to-clear, a same-cycle set beats the clear
  always_ff @(posedge clk_m2s) begin
    if (rst_m2s) begin
      ewif_q <= 1'b0;
    end else if (ew_set) begin
      ewif_q <= 1'b1;
    end else if (sr_wr && dat_m2s[SR_EWIF]) begin
      ewif_q <= 1'b0;
    end
  end

  assign irq_ew = ewif_q && ewie_q;

  // ---------------------------------------------------------------- state machine
  // State register
  always_ff @(posedge clk_m2s) begin
    if (rst_m2s) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: the start key arms the watchdog, only a bus reset disarms it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (key_start) state_d = RUN;
      RUN:  state_d = RUN;
    endcase
  end

  // State decode: start only counts from IDLE, refresh only counts in RUN
  always_comb begin
    running    = (state_q == RUN);
    start_go   = (state_q == IDLE) && key_start;
    refresh_go = (state_q == RUN) && key_refresh;
  end

  // ---------------------------------------------------------------- counter
  // A refresh on the same cycle as a tick swallows the tick
  assign tick_eff      = tick && !refresh_go;
  assign timeout       = tick_eff && (cnt_q == '0);
  assign violation     = refresh_go && (cnt_q > winr_q);
  assign cnt_tick_next = (cnt_q == '0) ? rlr_q : cnt_q - 1'b1;
  assign ew_set        = tick_eff && ewie_q && (cnt_tick_next == ewthr_q);

  // A violating refresh reloads the counter but keeps the prescaler phase
  assign presc_clear = start_go || (refresh_go && !violation) || pr_wr;

  wdg_prescaler #(
    .PR_W (PR_W)
  ) u_prescaler (
    .clk_m2s (clk_m2s),
    .rst_m2s (rst_m2s),
    .enable  (running),
    .clear   (presc_clear),
    .sel     (pr_q),
    .tick    (tick)
  );

  // Down-counter: reload on start/refresh, otherwise step on each tick
  always_ff @(posedge clk_m2s) begin
    if (rst_m2s) begin
      cnt_q <= '1;
    end else if (start_go || refresh_go) begin
      cnt_q <= rlr_q;
    end else if (tick_eff) begin
      cnt_q <= cnt_tick_next;
    end
  end

  // Reset stretcher: each timeout or violation (re)starts a RST_CYCLES-long pulse
  always_ff @(posedge clk_m2s) begin
    if (rst_m2s) begin
      rst_left_q <= '0;
    end else if (timeout || violation) begin
      rst_left_q <= RST_W'(RST_CYCLES);
    end else if (rst_left_q != '0) begin
      rst_left_q <= rst_left_q - 1'b1;
    end
  end

  assign rst_wdg = (rst_left_q != '0);

endmodule

// File: tb/tb_wdg_window_wb.sv
`timescale 1ns/1ps
module tb_wdg_window_wb;

  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam int          RSTC = 4;

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic [31:0] adr     = '0;
  logic [15:0] dat_w   = '0;
  logic        cyc     = 1'b0;
  logic        stb     = 1'b0;
  logic        we      = 1'b0;
  logic [15:0] dat_r;
  logic        ack;
  logic        rst_wdg;
  logic        irq_ew;

  always #5 clk = ~clk;

  wdg_window_wb dut (
    .clk_m2s (clk),
    .rst_m2s (rst),
    .adr_m2s (adr),
    .dat_m2s (dat_w),
    .cyc_m2s (cyc),
    .stb_m2s (stb),
    .we_m2s  (we),
    .dat_s2m (dat_r),
    .ack_s2m (ack),
    .rst_wdg (rst_wdg),
    .irq_ew  (irq_ew)
  );

  int checks = 0;
  int passes = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ------------------------------------------------------------ reference model
  // Time-based view: the prescaler phase is the distance from the last restart
  // modulo the divide period; counter and flags follow the rules per cycle.
  int t = 0;
  bit m_ack = 0, m_run = 0, m_unl = 0, m_ewie = 0, m_ewif = 0;
  int m_pr = 0, m_rlr = 4095, m_winr = 4095, m_thr = 0, m_cnt = 4095;
  int m_tbase = 0, m_rst_left = 0;

  function automatic int period();
    return 1 << (((m_pr > 6) ? 6 : m_pr) + 2);
  endfunction

  function automatic int phase();
    return (t - m_tbase) % period();
  endfunction

  function automatic logic [15:0] model_read(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    case (o)
      32'h04:  return 16'(m_pr);
      32'h08:  return 16'(m_rlr);
      32'h0C:  return {13'b0, m_unl, m_ewif, m_run};
      32'h10:  return 16'(m_winr);
      32'h14:  return 16'(m_thr) | (m_ewie ? 16'h8000 : 16'h0000);
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin : model
    bit wr, tick, refresh, evt, nxt_ewif, nxt_run;
    int nxt_cnt, nxt_tbase;
    logic [31:0] o;
    if (rst) begin
      m_ack = 0; m_run = 0; m_unl = 0; m_ewie = 0; m_ewif = 0;
      m_pr = 0; m_rlr = 4095; m_winr = 4095; m_thr = 0; m_cnt = 4095;
      m_rst_left = 0;
    end else begin
      o        = adr - BASE;
      wr       = m_ack && cyc && stb && we;
      tick     = m_run && (phase() == period() - 1);
      refresh  = wr && (o == 0) && (dat_w == 16'hAAAA) && m_run;
      evt      = 0;
      nxt_cnt  = m_cnt;
      nxt_tbase = m_tbase;
      nxt_ewif = m_ewif;
      nxt_run  = m_run;
      if (wr && (o == 32'h0C) && dat_w[1]) nxt_ewif = 0;
      if (refresh) begin
        if (m_cnt > m_winr) evt = 1;
        else nxt_tbase = t + 1;
        nxt_cnt = m_rlr;
      end else if (tick) begin
        if (m_cnt == 0) begin
          evt = 1;
          nxt_cnt = m_rlr;
        end else begin
          nxt_cnt = m_cnt - 1;
        end
        if (m_ewie && nxt_cnt == m_thr) nxt_ewif = 1;
      end
      if (wr && (o == 0) && (dat_w == 16'hCCCC) && !m_run) begin
        nxt_run = 1;
        nxt_cnt = m_rlr;
        nxt_tbase = t + 1;
      end
      if (wr && m_unl) begin
        case (o)
          32'h04: begin m_pr = int'(dat_w[2:0]); nxt_tbase = t + 1; end
          32'h08: m_rlr = int'(dat_w[11:0]);
          32'h10: m_winr = int'(dat_w[11:0]);
          32'h14: begin m_thr = int'(dat_w[11:0]); m_ewie = dat_w[15]; end
          default: ;
        endcase
      end
      if (wr && (o == 0)) m_unl = (dat_w == 16'h5555);
      m_rst_left = evt ? RSTC : ((m_rst_left > 0) ? m_rst_left - 1 : 0);
      m_cnt   = nxt_cnt;
      m_tbase = nxt_tbase;
      m_ewif  = nxt_ewif;
      m_run   = nxt_run;
      m_ack   = cyc && stb && !m_ack;
    end
    t++;
  end

  // ------------------------------------------------------------ monitor
  always @(negedge clk) begin : monitor
    chk("ack", 32'(ack), 32'(m_ack));
    chk("rst_wdg", 32'(rst_wdg), 32'(m_rst_left > 0));
    chk("irq_ew", 32'(irq_ew), 32'(m_ewif && m_ewie));
    if (ack && !we) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL rd_unexpected: read ack with data 0x%0h, no read pending (t=%0t)", dat_r, $time);
      end else begin
        chk("rd_dat", 32'(dat_r), 32'(exp_q.pop_front()));
      end
    end else if (!ack) begin
      chk("dat_idle", 32'(dat_r), 32'h0);
    end
  end

  // ------------------------------------------------------------ driver
  task automatic bus(input bit w, input logic [31:0] o, input logic [15:0] d);
    adr = BASE + o; dat_w = d; we = w; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    if (!w) exp_q.push_back(model_read(BASE + o));
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; dat_w = '0;
  endtask

  task automatic wr(input logic [31:0] o, input logic [15:0] d);
    bus(1'b1, o, d);
  endtask

  task automatic rd(input logic [31:0] o);
    bus(1'b0, o, 16'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(2); rst = 1'b0;
  endtask

  // Park until a strobe issued now lands its ack on a cycle where cnt == target,
  // with (want_tick) or without a coinciding prescaler tick
  task automatic wait_cnt(input int target, input bit want_tick);
    int n = 0;
    while (!(m_run && m_cnt == target &&
             (want_tick ? (phase() == period() - 2) : (phase() < period() - 2))) && n < 3000) begin
      idle(1); n++;
    end
    if (n >= 3000) begin
      checks++;
      $display("FAIL wait_cnt: cnt=%0d never reached %0d", m_cnt, target);
    end
  endtask

  task automatic wait_flag(input string name, input bit rst_pulse);
    int n = 0;
    while (!(rst_pulse ? (m_rst_left > 0) : m_ewif) && n < 3000) begin idle(1); n++; end
    if (n >= 3000) begin
      checks++;
      $display("FAIL wait_%s: event never happened", name);
    end
  endtask

  initial begin
    logic [31:0] offs [8];
    logic [15:0] keys [4];
    offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h02};
    keys = '{16'h5555, 16'hAAAA, 16'hCCCC, 16'h1234};

    idle(3); rst = 1'b0; idle(1);

    // Reset state reads
    rd(32'h0C); rd(32'h00); rd(32'h08); rd(32'h14); rd(32'h18);

    // Start with PR = 0, RLR = 3, let it time out twice
    wr(32'h00, 16'h5555); wr(32'h04, 16'h0); wr(32'h08, 16'h3);
    wr(32'h00, 16'hCCCC); rd(32'h0C);
    idle(40);

    // Lock protection
    do_reset();
    wr(32'h08, 16'h5); rd(32'h08);
    wr(32'h00, 16'h5555); wr(32'h08, 16'h5); rd(32'h08);
    wr(32'h00, 16'hAAAA); rd(32'h0C);

    // Window: refresh too early, then inside the window
    do_reset();
    wr(32'h00, 16'h5555); wr(32'h10, 16'h2); wr(32'h08, 16'h7); wr(32'h00, 16'hCCCC);
    wait_cnt(5, 1'b0); wr(32'h00, 16'hAAAA);
    idle(2);
    wait_cnt(2, 1'b0); wr(32'h00, 16'hAAAA);
    idle(20);

    // Early warning and its clear
    do_reset();
    wr(32'h00, 16'h5555); wr(32'h14, 16'h8003); wr(32'h08, 16'h6); wr(32'h00, 16'hCCCC);
    wait_flag("ewif", 1'b0);
    idle(3); rd(32'h0C); wr(32'h0C, 16'h0002); rd(32'h0C); idle(3);

    // Refresh colliding with the timeout tick, then bus reset mid-pulse
    do_reset();
    wr(32'h00, 16'h5555); wr(32'h08, 16'h3); wr(32'h00, 16'hCCCC);
    wait_cnt(0, 1'b1); wr(32'h00, 16'hAAAA);
    idle(5);
    wait_flag("rst_pulse", 1'b1);
    idle(1);
    rst = 1'b1; idle(1); rst = 1'b0;
    rd(32'h0C);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int k;
      k = $urandom_range(0, 19);
      if (k < 5) wr(32'h00, keys[$urandom_range(0, 3)]);
      else if (k == 5) wr(32'h04, ($urandom_range(0, 3) == 3) ? 16'h7 : 16'($urandom_range(0, 1)));
      else if (k == 6) wr(32'h08, 16'($urandom_range(0, 12)));
      else if (k == 7) wr(32'h10, ($urandom_range(0, 1) == 1) ? 16'h0FFF : 16'($urandom_range(0, 12)));
      else if (k == 8) wr(32'h14, 16'($urandom_range(0, 1) << 15) | 16'($urandom_range(0, 8)));
      else if (k == 9) wr(32'h0C, 16'($urandom_range(0, 7)));
      else if (k == 10) wr(offs[$urandom_range(6, 7)], 16'($urandom));
      else if (k < 15) rd(offs[$urandom_range(0, 7)]);
      else if (k == 15 && $urandom_range(0, 9) == 0) do_reset();
      else idle($urandom_range(0, 25));
    end
    idle(5);

    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL rd_pending: %0d reads never acked", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
